star_mapper: RTL and testbench

Controller that sequences the shared 36x3 pixel RAM to map one star once the raster scanner has found a lit seed pixel. It is started by the scan FSM's `goStarMap` level. It scans a clipped window around the seed, builds the star's bounding box, and erases every lit pixel it visits (writes 0) so the scanner never re-detects it. While busy it owns the single RAM port; the top level muxes the RAM address, write-enable and data from this block whenever `busy` is high.

---
 rtl/star_pkg.sv | 19 +
 rtl/pix_addr_calc.sv | 17 +
 rtl/star_mapper.sv | 116 +++++++++++
 tb/tb_star_mapper.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// star_pkg: shared defaults, FSM states and bounding-box type for the star mapper
package star_pkg;
   localparam int DEF_IMG_W     = 6;
   localparam int DEF_IMG_H     = 6;
   localparam int DEF_WIN       = 3;
   localparam int DEF_THRESHOLD = 0;
   localparam int DEF_XY_SZ     = 3;
   localparam int DEF_ADDR_SZ   = 6;
   localparam int DEF_COL_SZ    = 3;

   typedef enum logic [2:0] {IDLE, INIT, RD, EVAL, ERASE, DONE} state_t;

   typedef struct packed {
      logic [DEF_XY_SZ-1:0] x0;
      logic [DEF_XY_SZ-1:0] y0;
      logic [DEF_XY_SZ-1:0] x1;
      logic [DEF_XY_SZ-1:0] y1;
   } box_t;
endpackage

// File: rtl/pix_addr_calc.sv
// pix_addr_calc: linear pixel address y*IMG_W+x built from shifted copies of y
module pix_addr_calc #(
   parameter int IMG_W   = 6,
   parameter int XY_SZ   = 3,
   parameter int ADDR_SZ = 6
) (
   input  logic [XY_SZ-1:0]   x,
   input  logic [XY_SZ-1:0]   y,
   output logic [ADDR_SZ-1:0] addr
);
   localparam logic [ADDR_SZ-1:0] W = ADDR_SZ'(IMG_W);
   always_comb begin
      addr = ADDR_SZ'(x);
      for (int i = 0; i < ADDR_SZ; i++)
         if (W[i]) addr = addr + (ADDR_SZ'(y) << i);
   end
endmodule

// File: rtl/star_mapper.sv
// star_mapper: scans a clipped window below a seed pixel, boxes the star and erases its pixels
module star_mapper
   import star_pkg::*;
#(
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IMG_H     = DEF_IMG_H,
   parameter int WIN       = DEF_WIN,
   parameter int THRESHOLD = DEF_THRESHOLD,
   parameter int XY_SZ     = DEF_XY_SZ,
   parameter int ADDR_SZ   = DEF_ADDR_SZ,
   parameter int COL_SZ    = DEF_COL_SZ
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [XY_SZ-1:0]   seedX,
   input  logic [XY_SZ-1:0]   seedY,
   input  logic [COL_SZ-1:0]  ramQ,
   output logic [ADDR_SZ-1:0] ramAddr,
   output logic               ramWrEn,
   output logic [COL_SZ-1:0]  ramData,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [XY_SZ-1:0]   boxX0,
   output logic [XY_SZ-1:0]   boxY0,
   output logic [XY_SZ-1:0]   boxX1,
   output logic [XY_SZ-1:0]   boxY1,
   output logic [ADDR_SZ-1:0] pixCount,
   output logic [COL_SZ-1:0]  starCol
);
   localparam int IW = XY_SZ + 1;
   state_t state, nxt;
   logic [XY_SZ-1:0] sx, sy, x, y, xs, xe, ye, xs_n, xe_n, ye_n;
   box_t box;
   logic lit, last;

   pix_addr_calc #(.IMG_W(IMG_W), .XY_SZ(XY_SZ), .ADDR_SZ(ADDR_SZ)) addr_calc (
      .x(x),
      .y(y),
      .addr(ramAddr)
   );

   // bounds are compared one bit wider so seed plus reach cannot wrap
   always_comb begin
      xs_n = ({1'b0, sx} >= IW'(WIN - 1)) ? sx - XY_SZ'(WIN - 1) : '0;
      xe_n = ({1'b0, sx} + IW'(WIN - 1) > IW'(IMG_W - 1)) ? XY_SZ'(IMG_W - 1) : sx + XY_SZ'(WIN - 1);
      ye_n = ({1'b0, sy} + IW'(WIN - 1) > IW'(IMG_H - 1)) ? XY_SZ'(IMG_H - 1) : sy + XY_SZ'(WIN - 1);
   end

   assign lit      = ramQ > COL_SZ'(THRESHOLD);
   assign last     = (x == xe) && (y == ye);
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign ramWrEn  = (state == ERASE) && !reset;
   assign ramData  = '0;
   assign boxX0    = box.x0;
   assign boxY0    = box.y0;
   assign boxX1    = box.x1;
   assign boxY1    = box.y1;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = go ? INIT : IDLE;
         INIT:    nxt = RD;
         RD:      nxt = EVAL;
         EVAL:    nxt = lit ? ERASE : last ? DONE : RD;
         ERASE:   nxt = last ? DONE : RD;
         DONE:    nxt = go ? DONE : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         {sx, sy, x, y, xs, xe, ye} <= '0;
         box <= '0;
         found <= 1'b0;
         pixCount <= '0;
         starCol <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && go) begin
            sx <= seedX;
            sy <= seedY;
         end
         if (state == INIT) begin
            xs <= xs_n;
            xe <= xe_n;
            ye <= ye_n;
            x <= xs_n;
            y <= sy;
            found <= 1'b0;
            pixCount <= '0;
            starCol <= '0;
            box <= '{sx, sy, sx, sy};
         end
         if (state == EVAL && lit) begin
            box.x0 <= (x < box.x0) ? x : box.x0;
            box.y0 <= (y < box.y0) ? y : box.y0;
            box.x1 <= (x > box.x1) ? x : box.x1;
            box.y1 <= (y > box.y1) ? y : box.y1;
            pixCount <= pixCount + ADDR_SZ'(1);
            found <= 1'b1;
            if (!found) starCol <= ramQ;
         end
         // the last position is held so the address never leaves the window
         if (((state == EVAL && !lit) || state == ERASE) && !last) begin
            x <= (x == xe) ? xs : x + XY_SZ'(1);
            y <= (x == xe) ? y + XY_SZ'(1) : y;
         end
      end
   end
endmodule

// File: tb/tb_star_mapper.sv
// tb_star_mapper: random and directed star runs checked against a window-walk model
module tb_star_mapper;
   import star_pkg::*;
   logic clk = 0, reset = 1, go = 0, ld = 0;
   logic [2:0] seedX = 0, seedY = 0, ramQ = 0, ramData, starCol;
   logic [5:0] ramAddr, pixCount;
   logic ramWrEn, busy, done, found;
   logic [2:0] boxX0, boxY0, boxX1, boxY1;
   logic [2:0] mem [36];
   logic [2:0] ld_img [36];
   logic [2:0] ref_mem [36];
   bit win [36];
   bit lit_set [36];
   int checks = 0, errors = 0, wr_cnt = 0;
   int e_found, e_x0, e_y0, e_x1, e_y1, e_cnt, e_col, e_lat, e_n;
   int o_lat, o_found, o_x0, o_y0, o_x1, o_y1, o_cnt, o_col, o_nseen;

   always #10 clk = ~clk;

   star_mapper dut (
      .clk(clk), .reset(reset), .go(go), .seedX(seedX), .seedY(seedY), .ramQ(ramQ),
      .ramAddr(ramAddr), .ramWrEn(ramWrEn), .ramData(ramData), .busy(busy), .done(done),
      .found(found), .boxX0(boxX0), .boxY0(boxY0), .boxX1(boxX1), .boxY1(boxY1),
      .pixCount(pixCount), .starCol(starCol)
   );

   always @(posedge clk) begin
      if (ld) mem <= ld_img;
      else if (ramAddr < 36) begin
         if (ramWrEn) mem[ramAddr] <= ramData;
         ramQ <= mem[ramAddr];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (ramWrEn) begin
         wr_cnt++;
         chk("write_to_lit_pixel", (ramAddr < 36) ? int'(lit_set[ramAddr]) : 0, 1);
      end

   task automatic commit();
      ref_mem = ld_img;
      @(negedge clk); ld = 1;
      @(negedge clk); ld = 0;
   endtask

   task automatic load_random(input int density);
      foreach (ld_img[i]) ld_img[i] = ($urandom_range(99) < density) ? 3'($urandom_range(7, 1)) : 3'd0;
      commit();
   endtask

   task automatic predict(input int sx, input int sy);
      int xs, xe, ye, a;
      xs = (sx >= DEF_WIN - 1) ? sx - (DEF_WIN - 1) : 0;
      xe = (sx + DEF_WIN - 1 > DEF_IMG_W - 1) ? DEF_IMG_W - 1 : sx + DEF_WIN - 1;
      ye = (sy + DEF_WIN - 1 > DEF_IMG_H - 1) ? DEF_IMG_H - 1 : sy + DEF_WIN - 1;
      e_found = 0; e_cnt = 0; e_col = 0; e_n = 0;
      e_x0 = sx; e_x1 = sx; e_y0 = sy; e_y1 = sy;
      foreach (win[i]) begin win[i] = 0; lit_set[i] = 0; end
      for (int yy = sy; yy <= ye; yy++)
         for (int xx = xs; xx <= xe; xx++) begin
            a = yy * DEF_IMG_W + xx;
            win[a] = 1;
            e_n++;
            if (ref_mem[a] > 3'(DEF_THRESHOLD)) begin
               if (e_found == 0) e_col = ref_mem[a];
               e_found = 1;
               e_cnt++;
               if (xx < e_x0) e_x0 = xx;
               if (xx > e_x1) e_x1 = xx;
               if (yy < e_y0) e_y0 = yy;
               if (yy > e_y1) e_y1 = yy;
               lit_set[a] = 1;
               ref_mem[a] = 0;
            end
         end
      e_lat = 1 + 2 * e_n + e_cnt;
   endtask

   task automatic run(input int sx, input int sy, input int hold);
      bit seen [36];
      int n, bad, mism;
      n = 0; bad = 0; mism = 0; o_nseen = 0;
      predict(sx, sy);
      wr_cnt = 0;
      @(negedge clk); go = 1; seedX = 3'(sx); seedY = 3'(sy);
      @(posedge clk); #1;
      chk("busy_after_start", busy, 1);
      while (!done && n < 400) begin
         @(posedge clk); #1; n++;
         if (ramAddr > 35 || !win[ramAddr]) bad++;
         else if (!seen[ramAddr]) begin seen[ramAddr] = 1; o_nseen++; end
      end
      o_lat = n; o_found = found; o_cnt = pixCount; o_col = starCol;
      o_x0 = boxX0; o_y0 = boxY0; o_x1 = boxX1; o_y1 = boxY1;
      chk("latency", o_lat, e_lat);
      chk("addr_in_window", bad, 0);
      chk("window_coverage", o_nseen, e_n);
      chk("found", o_found, e_found);
      chk("pixCount", o_cnt, e_cnt);
      chk("starCol", o_col, e_col);
      chk("boxX0", o_x0, e_x0);
      chk("boxY0", o_y0, e_y0);
      chk("boxX1", o_x1, e_x1);
      chk("boxY1", o_y1, e_y1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("done_held", done, 1);
         chk("count_stable", pixCount, e_cnt);
      end
      @(negedge clk); go = 0;
      @(posedge clk); #1;
      chk("done_drop", done, 0);
      chk("busy_drop", busy, 0);
      chk("write_count", wr_cnt, e_cnt);
      foreach (mem[i]) if (mem[i] !== ref_mem[i]) mism++;
      chk("ram_image", mism, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", int'(|{ramAddr, ramWrEn, ramData, busy, done, found, boxX0, boxY0, boxX1, boxY1, pixCount, starCol}), 0);
      @(negedge clk); reset = 0;

      // lone pixel at origin with a lit pixel just outside the clipped window
      foreach (ld_img[i]) ld_img[i] = 0;
      ld_img[0] = 3'b101; ld_img[3] = 3'd4;
      commit();
      run(0, 0, 5);
      chk("lone_latency", o_lat, 20);
      chk("lone_col", o_col, 5);
      chk("lone_box", o_x0 + o_y0 + o_x1 + o_y1, 0);
      chk("lone_ram0", mem[0], 0);
      chk("lone_ram3", mem[3], 4);

      // cluster, started right after the previous return to IDLE
      foreach (ld_img[i]) ld_img[i] = 0;
      ld_img[8] = 1; ld_img[9] = 2; ld_img[13] = 3; ld_img[14] = 4; ld_img[11] = 7; ld_img[0] = 6;
      commit();
      run(2, 1, 0);
      chk("cluster_latency", o_lat, 35);
      chk("cluster_count", o_cnt, 4);
      chk("cluster_box", o_x0 * 1000 + o_y0 * 100 + o_x1 * 10 + o_y1, 1132);
      chk("cluster_col", o_col, 1);
      chk("cluster_keep11", mem[11], 7);

      // bottom-right corner clip
      foreach (ld_img[i]) ld_img[i] = 0;
      ld_img[34] = 2;
      commit();
      run(5, 5, 1);
      chk("corner_positions", o_nseen, 3);
      chk("corner_latency", o_lat, 8);

      // unlit seed in an empty window
      foreach (ld_img[i]) ld_img[i] = 0;
      ld_img[0] = 5;
      commit();
      run(3, 2, 2);
      chk("empty_found", o_found, 0);
      chk("empty_box", o_x0 * 1000 + o_y0 * 100 + o_x1 * 10 + o_y1, 3232);
      chk("empty_writes", wr_cnt, 0);

      for (int r = 0; r < 25; r++) begin
         if (r % 3 == 0) load_random($urandom_range(70, 15));
         run($urandom_range(5), $urandom_range(5), $urandom_range(3));
      end

      // reset while the first erase is pending
      foreach (ld_img[i]) ld_img[i] = 0;
      ld_img[0] = 6;
      commit();
      foreach (lit_set[i]) lit_set[i] = 0;
      @(negedge clk); go = 1; seedX = 0; seedY = 0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ramWrEn && n < 20);
      chk("erase_reached", ramWrEn, 1);
      reset = 1; go = 0;
      #1 chk("wren_gated", ramWrEn, 0);
      @(posedge clk); #1;
      chk("reset_mid_outputs", int'(|{ramAddr, ramWrEn, ramData, busy, done, found, boxX0, boxY0, boxX1, boxY1, pixCount, starCol}), 0);
      chk("reset_no_write", mem[0], 6);
      @(negedge clk); reset = 0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
